// File: rtl/modsqr_sequencer_pkg.sv
// modsqr_sequencer_pkg: shared widths and FSM state type for the modular-squaring sequencer.
package modsqr_sequencer_pkg;
  localparam int LOGNUMSYMBOLS = 5;
  localparam int LOGRADIX = 33;
  localparam int SYMBOLBITS = LOGRADIX + 2;
  localparam int NUMSYMBOLS = 1 << LOGNUMSYMBOLS;
  localparam int OPW = NUMSYMBOLS * SYMBOLBITS;
  typedef enum logic [2:0] {IDLE, LOAD, ISSUE, WAIT, DONE} seq_state_t;
endpackage

// File: rtl/modsqr_sequencer_watchdog.sv
// latency_watchdog: down-counter that classifies a datapath return as on time, early or late.
module latency_watchdog #(
  parameter int LATENCY = 8
) (
  input  logic clk,
  input  logic rst_n,
  input  logic load,
  input  logic active,
  input  logic hit,
  output logic on_time,
  output logic early,
  output logic late
);
  localparam int W = $clog2(LATENCY + 1);
  logic [W-1:0] cnt;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt <= '0;
    else if (load) cnt <= W'(LATENCY - 1);
    else if (cnt != '0) cnt <= cnt - W'(1);
  end
  assign on_time = active & hit & (cnt == '0);
  assign early = active & hit & (cnt != '0);
  assign late = active & ~hit & (cnt == '0);
endmodule

// File: rtl/modsqr_sequencer.sv
// modsqr_sequencer: issues an operand to the squaring pipeline, recirculates each result for a
// programmed number of iterations, and flags any result that misses the fixed pipeline latency.
module modsqr_sequencer
  import modsqr_sequencer_pkg::*;
#(
  parameter int PIPE_LATENCY = 8,
  parameter int ITERBITS = 64
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start_in,
  input  logic [ITERBITS-1:0] iterations_in,
  input  logic [OPW-1:0]      sq_in,
  input  logic                abort_in,
  output logic                dp_valid_out,
  output logic [OPW-1:0]      dp_data_out,
  input  logic                dp_valid_in,
  input  logic [OPW-1:0]      dp_data_in,
  output logic                busy_out,
  output logic                done_out,
  input  logic                ack_in,
  output logic [OPW-1:0]      sq_out,
  output logic [ITERBITS-1:0] iter_count_out,
  output logic                err_latency_out
);
  seq_state_t state;
  logic [OPW-1:0] op;
  logic [ITERBITS-1:0] target, iter_next;
  logic on_time, early, late;
  assign iter_next = iter_count_out + ITERBITS'(1);
  assign busy_out = (state == LOAD) || (state == ISSUE) || (state == WAIT);
  assign done_out = state == DONE;
  // An abort must never let an issue strobe escape, even in the ISSUE cycle itself.
  assign dp_valid_out = (state == ISSUE) && !abort_in;
  latency_watchdog #(.LATENCY(PIPE_LATENCY)) u_watchdog (
    .clk(clk), .rst_n(rst_n), .load(state == ISSUE), .active(state == WAIT),
    .hit(dp_valid_in), .on_time(on_time), .early(early), .late(late)
  );
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      op <= '0;
      target <= '0;
      dp_data_out <= '0;
      sq_out <= '0;
      iter_count_out <= '0;
      err_latency_out <= 1'b0;
    end else if (abort_in && state != IDLE) begin
      state <= IDLE;
    end else begin
      case (state)
        IDLE: if (start_in) begin
          err_latency_out <= 1'b0;
          iter_count_out <= '0;
          if (iterations_in == '0) begin
            sq_out <= sq_in;
            state <= DONE;
          end else begin
            op <= sq_in;
            target <= iterations_in;
            state <= LOAD;
          end
        end
        LOAD: begin
          dp_data_out <= op;
          state <= ISSUE;
        end
        ISSUE: state <= WAIT;
        WAIT: if (on_time) begin
          op <= dp_data_in;
          iter_count_out <= iter_next;
          if (iter_next == target) begin
            sq_out <= dp_data_in;
            state <= DONE;
          end else begin
            dp_data_out <= dp_data_in;
            state <= ISSUE;
          end
        end else if (early || late) begin
          err_latency_out <= 1'b1;
          sq_out <= op;
          state <= DONE;
        end
        DONE: if (ack_in) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_modsqr_sequencer.sv
// tb_modsqr_sequencer: randomized and directed scoreboard bench with a latency-programmable stub datapath.
module tb_modsqr_sequencer;
  import modsqr_sequencer_pkg::*;
  localparam int L = 8;
  logic clk = 1'b0, rst_n = 1'b0, start_in = 1'b0, abort_in = 1'b0, dp_valid_in = 1'b0, ack_in = 1'b0;
  logic [63:0] iterations_in = '0;
  logic [OPW-1:0] sq_in = '0, dp_data_in = '0;
  logic dp_valid_out, busy_out, done_out, err_latency_out;
  logic [OPW-1:0] dp_data_out, sq_out;
  logic [63:0] iter_count_out;
  modsqr_sequencer #(.PIPE_LATENCY(L), .ITERBITS(64)) dut (
    .clk(clk), .rst_n(rst_n), .start_in(start_in), .iterations_in(iterations_in), .sq_in(sq_in),
    .abort_in(abort_in), .dp_valid_out(dp_valid_out), .dp_data_out(dp_data_out),
    .dp_valid_in(dp_valid_in), .dp_data_in(dp_data_in), .busy_out(busy_out), .done_out(done_out),
    .ack_in(ack_in), .sq_out(sq_out), .iter_count_out(iter_count_out), .err_latency_out(err_latency_out)
  );
  always #5 clk = ~clk;
  typedef struct {
    logic [OPW-1:0] sq;
    logic [63:0] cnt;
    bit err;
    int issues;
  } exp_t;
  exp_t sb[$];
  int sched[16];
  int checks = 0, failures = 0;
  int issues = 0;
  task automatic check(input string name, input bit ok, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, req);
    end
  endtask
  // The stub datapath increments symbol 0 of whatever it is given.
  function automatic logic [OPW-1:0] bump(input logic [OPW-1:0] v);
    logic [OPW-1:0] r;
    r = v;
    r[SYMBOLBITS-1:0] = v[SYMBOLBITS-1:0] + SYMBOLBITS'(1);
    return r;
  endfunction
  // Reference: iterate until the target or the first iteration whose return latency is not L.
  function automatic exp_t model(input logic [OPW-1:0] sq, input logic [63:0] n);
    exp_t e;
    e.sq = sq; e.cnt = n; e.err = 1'b0; e.issues = int'(n);
    for (int k = 0; k < int'(n); k++) begin
      if (sched[k] != L) begin
        e.cnt = 64'(k); e.err = 1'b1; e.issues = k + 1;
        return e;
      end
      e.sq = bump(e.sq);
    end
    return e;
  endfunction
  function automatic logic [OPW-1:0] rand_op();
    logic [OPW-1:0] v;
    for (int w = 0; w < OPW / 32; w++) v[w*32 +: 32] = $urandom();
    return v;
  endfunction
  task automatic set_sched(input int lat);
    for (int k = 0; k < 16; k++) sched[k] = lat;
  endtask
  task automatic tick();
    @(posedge clk); #1;
  endtask
  initial begin : stub
    int cyc, pend_at, last_issue;
    bit pend;
    logic [OPW-1:0] pend_data;
    cyc = 0; pend = 0; pend_at = 0; last_issue = 0; pend_data = '0;
    forever begin
      @(posedge clk); #2;
      cyc++;
      dp_valid_in = 1'b0;
      if (!rst_n || start_in) begin
        pend = 0;
        issues = 0;
      end else begin
        if (pend && cyc == pend_at) begin
          dp_valid_in = 1'b1;
          dp_data_in = pend_data;
          pend = 0;
        end
        if (dp_valid_out) begin
          if (issues > 0) check("issue_spacing", cyc == last_issue + L + 1, 64'(cyc - last_issue), 64'(L + 1));
          if (issues < 16 && sched[issues] > 0) begin
            pend = 1;
            pend_at = cyc + sched[issues];
            pend_data = bump(dp_data_out);
          end
          last_issue = cyc;
          issues++;
        end
      end
    end
  end
  initial begin : monitor
    bit prev;
    exp_t e;
    prev = 0;
    forever begin
      @(posedge clk); #1;
      if (done_out && !prev) begin
        if (sb.size() == 0) check("unexpected_done", 1'b0, 64'd1, 64'd0);
        else begin
          e = sb.pop_front();
          check("result_sq", sq_out == e.sq, sq_out[63:0], e.sq[63:0]);
          check("result_count", iter_count_out == e.cnt, iter_count_out, e.cnt);
          check("result_err", err_latency_out == e.err, 64'(err_latency_out), 64'(e.err));
          check("result_issues", issues == e.issues, 64'(issues), 64'(e.issues));
        end
      end
      prev = done_out;
    end
  end
  task automatic wait_issues(input int n);
    bit ok;
    ok = 0;
    for (int i = 0; i < 100; i++) begin
      if (issues == n) begin ok = 1; break; end
      tick();
    end
    if (!ok) check("issue_timeout", 1'b0, 64'(issues), 64'(n));
  endtask
  task automatic run(input logic [OPW-1:0] sq, input logic [63:0] n, input int hold);
    bit ok;
    logic [OPW-1:0] held;
    sb.push_back(model(sq, n));
    sq_in = sq; iterations_in = n; start_in = 1'b1;
    tick();
    start_in = 1'b0;
    if (n == 0) check("zero_iter_done", done_out, 64'(done_out), 64'd1);
    ok = 0;
    for (int i = 0; i < 300; i++) begin
      if (done_out) begin ok = 1; break; end
      tick();
    end
    if (!ok) begin
      check("done_timeout", 1'b0, 64'd0, 64'd1);
      abort_in = 1'b1; tick(); abort_in = 1'b0;
      sb.delete();
      return;
    end
    held = sq_out;
    for (int i = 0; i < hold; i++) begin
      start_in = i[0];
      tick();
      check("done_hold", done_out && sq_out == held, sq_out[63:0], held[63:0]);
    end
    start_in = hold > 0;
    ack_in = 1'b1;
    tick();
    start_in = 1'b0; ack_in = 1'b0;
    check("ack_to_idle", !done_out && !busy_out, 64'({done_out, busy_out}), 64'd0);
    tick(); tick();
  endtask
  initial begin : watchdog
    #500000;
    $display("FAIL global_timeout");
    $fatal(1);
  end
  initial begin : main
    logic [OPW-1:0] v;
    set_sched(L);
    tick();
    check("reset_outputs", {dp_valid_out, busy_out, done_out, err_latency_out} == 4'd0 && dp_data_out == '0
          && sq_out == '0 && iter_count_out == '0, iter_count_out, 64'd0);
    rst_n = 1'b1;
    tick();
    v = '0; v[7:0] = 8'h05;
    run(v, 64'd3, 0);
    v = '0; v[7:0] = 8'hAB;
    run(v, 64'd0, 0);
    sched[1] = 9;
    run(rand_op(), 64'd4, 0);
    sched[1] = 7;
    run(rand_op(), 64'd4, 0);
    set_sched(L);
    sq_in = rand_op(); iterations_in = 64'd5; start_in = 1'b1;
    tick();
    start_in = 1'b0;
    wait_issues(2);
    repeat (3) tick();
    abort_in = 1'b1;
    tick();
    abort_in = 1'b0;
    check("abort_idle", !busy_out && !done_out, 64'({busy_out, done_out}), 64'd0);
    check("abort_count_kept", iter_count_out == 64'd1, iter_count_out, 64'd1);
    repeat (10) tick();
    check("abort_late_ignored", !busy_out && !done_out && iter_count_out == 64'd1, iter_count_out, 64'd1);
    run(rand_op(), 64'd2, 0);
    run(rand_op(), 64'd2, 20);
    sq_in = rand_op(); iterations_in = 64'd3; start_in = 1'b1;
    tick();
    start_in = 1'b0;
    wait_issues(1);
    repeat (2) tick();
    #3 rst_n = 1'b0;
    #1;
    check("async_reset_outputs", {dp_valid_out, busy_out, done_out, err_latency_out} == 4'd0 && dp_data_out == '0
          && sq_out == '0 && iter_count_out == '0, iter_count_out, 64'd0);
    tick();
    rst_n = 1'b1;
    tick();
    run(rand_op(), 64'd2, 0);
    for (int t = 0; t < 12; t++) begin
      for (int k = 0; k < 16; k++) begin
        int r;
        r = int'($urandom_range(0, 2));
        sched[k] = ($urandom_range(0, 9) < 7) ? L : (r == 0 ? 7 : (r == 1 ? 9 : 0));
      end
      run(rand_op(), 64'($urandom_range(0, 5)), 0);
    end
    repeat (5) tick();
    check("scoreboard_drained", sb.size() == 0, 64'(sb.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/modsqr_sequencer.md
Name: modsqr_sequencer

Overview:
- Sequences the pipelined modular-squaring datapath (squarer -> modulolookup -> multisymbolsum200to1 -> feedback) for a VDF evaluation.
- Loads an initial value, issues it to the datapath, and recirculates each returned result for a programmed number of iterations.
- Checks that every result returns at the fixed pipeline latency.
- Presents the final redundant-form result with a done/ack handshake to the host-side interface logic.

Parameters:
- LOGNUMSYMBOLS, 5, log2 of the number of symbols per operand.
- LOGRADIX, 33, bits per symbol radix.
- SYMBOLBITS, LOGRADIX+2, stored width per redundant symbol.
- PIPE_LATENCY, 8, cycles from dp_valid_out to the matching dp_valid_in; legal range 1..255.
- ITERBITS, 64, width of the iteration counter.

Ports:
- clk  in  1  datapath clock.
- rst_n  in  1  asynchronous active-low reset.
- start_in  in  1  one-cycle pulse; accepted only in IDLE.
- iterations_in  in  ITERBITS  number of squarings, sampled with start_in.
- sq_in  in  (1<<LOGNUMSYMBOLS)*SYMBOLBITS  initial value, sampled with start_in.
- abort_in  in  1  level; forces return to IDLE.
- dp_valid_out  out  1  issue strobe to datapath.
- dp_data_out  out  (1<<LOGNUMSYMBOLS)*SYMBOLBITS  operand to datapath.
- dp_valid_in  in  1  result strobe from datapath.
- dp_data_in  in  (1<<LOGNUMSYMBOLS)*SYMBOLBITS  result from datapath.
- busy_out  out  1  high in LOAD, ISSUE, WAIT.
- done_out  out  1  high in DONE.
- ack_in  in  1  host consumed result.
- sq_out  out  (1<<LOGNUMSYMBOLS)*SYMBOLBITS  final result, held while done_out is high.
- iter_count_out  out  ITERBITS  completed squarings.
- err_latency_out  out  1  sticky latency-mismatch flag; cleared by the next accepted start.

Behaviour:
- Reset (async, rst_n=0): state=IDLE; all outputs 0; internal registers 0.
- States: IDLE, LOAD, ISSUE, WAIT, DONE.
- IDLE:
  - start_in=1 with iterations_in=0 -> DONE next cycle; sq_out=sq_in; iter_count_out=0.
  - start_in=1 with iterations_in>0 -> register sq_in and iterations_in, clear err_latency_out and iter_count_out -> LOAD.
- LOAD: one cycle; copy the operand register to dp_data_out -> ISSUE.
- ISSUE:
  - dp_valid_out=1 for exactly this one cycle, with dp_data_out stable.
  - Latency counter loads PIPE_LATENCY-1 -> WAIT.
- WAIT:
  - Counter decrements each cycle.
  - dp_valid_in is expected exactly in the cycle the counter reads 0, i.e. PIPE_LATENCY cycles after the ISSUE cycle.
  - On that cycle: capture dp_data_in into the operand register; iter_count_out+1.
    - If the new iter_count_out equals the target -> DONE, with sq_out=dp_data_in.
    - Else -> ISSUE. Steady-state cadence is one issue per PIPE_LATENCY+1 cycles.
  - Counter reaches 0 with no dp_valid_in -> set err_latency_out, go to DONE; sq_out = last operand.
  - dp_valid_in while counter > 0 -> set err_latency_out, go to DONE; sq_out = last operand.
- DONE:
  - done_out=1; sq_out and iter_count_out held.
  - ack_in=1 -> IDLE next cycle.
  - start_in is ignored until IDLE.
- Any state other than IDLE, with abort_in=1 -> IDLE next cycle:
  - dp_valid_out forced 0 that cycle; done_out=0; iter_count_out retains its value.
  - dp_valid_in arriving in IDLE is discarded.
- Simultaneous events:
  - abort_in has priority over ack_in, dp_valid_in and start_in.
  - start_in and ack_in together in DONE: ack_in is honoured; start_in is dropped.
- Counters:
  - iter_count_out is unsigned and compared with ==; target 2^ITERBITS-1 is legal.
  - No wrap-around is possible because the counter stops at the target.
- Data is treated as opaque redundant-form symbols; no arithmetic on data inside the sequencer.

Decomposition:
- vdfpackage gains:
  - seq_state_t enum (IDLE, LOAD, ISSUE, WAIT, DONE).
  - Operand width constant: (1<<LOGNUMSYMBOLS)*(LOGRADIX+2).
- Sub-module latency_watchdog (down-counter with early/late flag outputs, width $clog2(PIPE_LATENCY+1)).
  - Instantiated once by the sequencer; the FSM and data registers stay top-level.

Test Plan:
1. Stub datapath (PIPE_LATENCY=8, returns operand+1 per symbol 0); start with iterations_in=3, sq_in=0x05 -> three dp_valid_out pulses 9 cycles apart; done_out with sq_out symbol0=0x08, iter_count_out=3, err_latency_out=0.
2. iterations_in=0, sq_in=0xAB -> done_out one cycle after start_in; sq_out=0xAB; no dp_valid_out ever.
3. Stub returns at latency 9 on the 2nd iteration (iterations_in=4) -> err_latency_out=1; done_out; iter_count_out=1. Repeat with latency 7 -> same flags.
4. abort_in pulsed in WAIT of iteration 2 of 5 -> IDLE next cycle; busy_out=0; late dp_valid_in ignored; following start with iterations_in=2 completes normally with err cleared.
5. rst_n asserted asynchronously mid-WAIT (between clock edges) -> all outputs 0 immediately; after release, start_in works from IDLE.
6. In DONE, hold ack_in=0 for 20 cycles while toggling start_in -> sq_out stable, start ignored; ack_in=1 -> IDLE next cycle.
